// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with DEPTH stages, stall/flush control,
// write-back forwarding lookup and a retired-instruction counter.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int DEPTH  = 1,
  parameter int NSRC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [WB_W-1:0]         in_wb,
  input  logic [DATA_W-1:0]       in_read_data,
  input  logic [DATA_W-1:0]       in_alu_result,
  input  logic [REG_W-1:0]        in_write_reg,
  output logic                    out_valid,
  output logic [WB_W-1:0]         out_wb,
  output logic [DATA_W-1:0]       out_read_data,
  output logic [DATA_W-1:0]       out_alu_result,
  output logic [REG_W-1:0]        out_write_reg,
  input  logic [NSRC*REG_W-1:0]   src_reg,
  output logic [NSRC-1:0]         fwd_hit,
  output logic [NSRC*DATA_W-1:0]  fwd_data,
  output logic [31:0]             retire_count
);

  // Stage 0 is the youngest, stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]  valid_q;
  logic [WB_W-1:0]   wb_q   [DEPTH];
  logic [DATA_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] alu_q  [DEPTH];
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [31:0]       retire_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wb_q[k]  <= '0;
        rd_q[k]  <= '0;
        alu_q[k] <= '0;
        reg_q[k] <= '0;
      end
    end else if (!stall) begin
      // A bubble enters with an all-zero payload so it can never write back.
      valid_q[0] <= in_valid;
      wb_q[0]    <= in_valid ? in_wb         : '0;
      rd_q[0]    <= in_valid ? in_read_data  : '0;
      alu_q[0]   <= in_valid ? in_alu_result : '0;
      reg_q[0]   <= in_valid ? in_write_reg  : '0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        wb_q[k]    <= wb_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        alu_q[k]   <= alu_q[k-1];
        reg_q[k]   <= reg_q[k-1];
      end
    end
  end

  // The output entry has already reached the register file, so a flush
  // does not cancel its retirement; only a stall or reset does.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (valid_q[DEPTH-1] && !stall) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (valid_q[s] && wb_q[s][1] && (reg_q[s] != '0) &&
            (reg_q[s] == src_reg[i*REG_W +: REG_W])) begin
          fwd_hit[i] = 1'b1;
          fwd_data[i*DATA_W +: DATA_W] = wb_q[s][0] ? rd_q[s] : alu_q[s];
        end
      end
    end
  end

  assign out_valid      = valid_q[DEPTH-1];
  assign out_wb         = wb_q[DEPTH-1];
  assign out_read_data  = rd_q[DEPTH-1];
  assign out_alu_result = alu_q[DEPTH-1];
  assign out_write_reg  = reg_q[DEPTH-1];
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: a DEPTH=2 and a DEPTH=3 instance share
// the same input stream; expected values are hand-computed constants.
module tb_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [1:0]  in_wb;
  logic [31:0] in_read_data, in_alu_result;
  logic [4:0]  in_write_reg;
  logic [9:0]  src_reg;

  logic        d2_valid, d3_valid;
  logic [1:0]  d2_wb, d3_wb;
  logic [31:0] d2_rd, d3_rd, d2_alu, d3_alu, d2_ret, d3_ret;
  logic [4:0]  d2_reg, d3_reg;
  logic [1:0]  d2_hit, d3_hit;
  logic [63:0] d2_fwd, d3_fwd;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_wb(in_wb), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .out_valid(d2_valid), .out_wb(d2_wb),
    .out_read_data(d2_rd), .out_alu_result(d2_alu), .out_write_reg(d2_reg),
    .src_reg(src_reg), .fwd_hit(d2_hit), .fwd_data(d2_fwd), .retire_count(d2_ret)
  );

  wb_pipe_reg #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_wb(in_wb), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .out_valid(d3_valid), .out_wb(d3_wb),
    .out_read_data(d3_rd), .out_alu_result(d3_alu), .out_write_reg(d3_reg),
    .src_reg(src_reg), .fwd_hit(d3_hit), .fwd_data(d3_fwd), .retire_count(d3_ret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply one input vector, clock it in, then settle past the edge.
  task automatic step(input logic v, input logic [1:0] wb, input logic [31:0] rd,
                      input logic [31:0] alu, input logic [4:0] rg);
    in_valid      = v;
    in_wb         = wb;
    in_read_data  = rd;
    in_alu_result = alu;
    in_write_reg  = rg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    src_reg = {5'd7, 5'd7};

    // Reset held two cycles with a live input present
    step(1'b1, 2'b11, 32'h11, 32'h22, 5'd7);
    step(1'b1, 2'b11, 32'h11, 32'h22, 5'd7);
    chk("rst_d2_valid", d2_valid, 1'b0);
    chk("rst_d2_wb", d2_wb, 2'b00);
    chk("rst_d2_rd", d2_rd, 32'h0);
    chk("rst_d2_alu", d2_alu, 32'h0);
    chk("rst_d2_reg", d2_reg, 5'd0);
    chk("rst_d2_ret", d2_ret, 32'h0);
    chk("rst_d2_hit", d2_hit, 2'b00);
    chk("rst_d3_valid", d3_valid, 1'b0);
    chk("rst_d3_hit", d3_hit, 2'b00);

    // Latency: one entry followed by bubbles
    rst = 1'b0;
    src_reg = {5'd31, 5'd0};
    step(1'b1, 2'b10, 32'h0, 32'h0000000B, 5'd31);
    chk("lat_d3_e0_valid", d3_valid, 1'b0);
    chk("lat_d3_e0_hit", d3_hit, 2'b10);
    chk("lat_d3_e0_fwd", d3_fwd, {32'h0000000B, 32'h0});
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("lat_d3_e1_valid", d3_valid, 1'b0);
    chk("lat_d2_e1_valid", d2_valid, 1'b1);
    chk("lat_d2_e1_alu", d2_alu, 32'h0B);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("lat_d3_e2_valid", d3_valid, 1'b1);
    chk("lat_d3_e2_alu", d3_alu, 32'h0B);
    chk("lat_d3_e2_reg", d3_reg, 5'd31);
    chk("lat_d3_e2_wb", d3_wb, 2'b10);
    chk("lat_d3_e2_ret", d3_ret, 32'd0);
    chk("lat_d2_e2_valid", d2_valid, 1'b0);
    chk("lat_d2_e2_ret", d2_ret, 32'd1);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("lat_d3_e3_valid", d3_valid, 1'b0);
    chk("lat_d3_e3_ret", d3_ret, 32'd1);

    // Forwarding priority: youngest matching stage wins, r0 never hits
    src_reg = {5'd5, 5'd0};
    step(1'b1, 2'b10, 32'h5555, 32'h1234, 5'd5);
    step(1'b1, 2'b11, 32'hAAAA, 32'h9999, 5'd5);
    chk("fwd_hit", d3_hit, 2'b10);
    chk("fwd_data", d3_fwd, {32'hAAAA, 32'h0});
    step(1'b1, 2'b11, 32'h77, 32'h88, 5'd0);
    chk("fwd_r0_hit", d3_hit, 2'b10);
    chk("fwd_r0_data", d3_fwd, {32'hAAAA, 32'h0});
    chk("fwd_d3_out_alu", d3_alu, 32'h1234);
    chk("fwd_d3_out_rd", d3_rd, 32'h5555);
    chk("fwd_d3_out_ret", d3_ret, 32'd1);
    src_reg = {5'd0, 5'd0};
    #1;
    chk("fwd_r0_only", d2_hit, 2'b00);

    // Flush with a valid output: pipeline empties, retirement still counts
    flush = 1'b1;
    step(1'b1, 2'b11, 32'h1, 32'h2, 5'd6);
    flush = 1'b0;
    chk("flush_d3_valid", d3_valid, 1'b0);
    chk("flush_d3_ret", d3_ret, 32'd2);
    chk("flush_d2_ret", d2_ret, 32'd3);

    // Bubble safety: invalid input with a live-looking payload
    src_reg = {5'd9, 5'd9};
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 32'hF0F0, 32'h0F0F, 5'd9);
    chk("bub_d3_valid", d3_valid, 1'b0);
    chk("bub_d3_wb", d3_wb, 2'b00);
    chk("bub_d3_reg", d3_reg, 5'd0);
    chk("bub_d3_rd", d3_rd, 32'h0);
    chk("bub_d2_wb", d2_wb, 2'b00);
    chk("bub_d3_hit", d3_hit, 2'b00);
    chk("bub_d2_hit", d2_hit, 2'b00);

    // Stall then stall+flush on the DEPTH=2 instance
    step(1'b1, 2'b10, 32'h0, 32'h21, 5'd3);
    step(1'b1, 2'b11, 32'h42, 32'h43, 5'd4);
    chk("ld_d2_valid", d2_valid, 1'b1);
    chk("ld_d2_alu", d2_alu, 32'h21);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 32'hDEAD, 32'hBEEF, 5'd8);
      chk("stall_d2_valid", d2_valid, 1'b1);
      chk("stall_d2_alu", d2_alu, 32'h21);
      chk("stall_d2_reg", d2_reg, 5'd3);
      chk("stall_d2_ret", d2_ret, 32'd3);
    end
    src_reg = {5'd4, 5'd3};
    #1;
    chk("stall_d2_hit", d2_hit, 2'b11);
    chk("stall_d2_fwd", d2_fwd, {32'h42, 32'h21});
    flush = 1'b1;
    step(1'b1, 2'b11, 32'hDEAD, 32'hBEEF, 5'd8);
    stall = 1'b0;
    flush = 1'b0;
    chk("sf_d2_valid", d2_valid, 1'b0);
    chk("sf_d2_wb", d2_wb, 2'b00);
    chk("sf_d2_ret", d2_ret, 32'd3);
    chk("sf_d2_hit", d2_hit, 2'b00);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("sf_d2_empty", d2_valid, 1'b0);
    chk("sf_d2_ret2", d2_ret, 32'd3);

    // Counter wrap from a preloaded all-ones value
    u_d2.retire_q = 32'hFFFF_FFFF;
    step(1'b1, 2'b10, 32'h0, 32'h5A, 5'd2);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("wrap_pre", d2_ret, 32'hFFFF_FFFF);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("wrap_post", d2_ret, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
